// File: rtl/md_issue_ctrl_if.sv
// Bundle of X-stage request, multdiv handshake and writeback signals.
interface md_issue_ctrl_if;
  logic        x_is_mult;
  logic        x_is_div;
  logic [31:0] x_opA;
  logic [31:0] x_opB;
  logic [4:0]  x_rd;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Controller side
  modport master (
    input  x_is_mult, x_is_div, x_opA, x_opB, x_rd,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, wb_valid, wb_rd, wb_data
  );

  // Pipeline / multdiv side
  modport slave (
    output x_is_mult, x_is_div, x_opA, x_opB, x_rd,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller between the execute stage and multdiv.
// Latches a mul/div from X, pulses the unit start, stalls until the result
// (or a timeout) arrives, then presents one writeback beat.
module md_issue_ctrl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic            clock,
  input  logic            ctrl_reset_n,
  md_issue_ctrl_if.master bus
);

  localparam int unsigned CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]  EXC_RD   = 5'd30;
  localparam logic [31:0] EXC_MULT = 32'd4;
  localparam logic [31:0] EXC_DIV  = 32'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [31:0]   r_opA;
  logic [31:0]   r_opB;
  logic [4:0]    r_rd;
  logic          r_is_div;
  logic [CW-1:0] r_cnt;
  logic          r_ctrl_mult;
  logic          r_ctrl_div;
  logic          r_wb_valid;
  logic [4:0]    r_wb_rd;
  logic [31:0]   r_wb_data;

  logic          w_req;
  logic [31:0]   w_exc_code;

  assign w_req      = bus.x_is_mult | bus.x_is_div;
  assign w_exc_code = r_is_div ? EXC_DIV : EXC_MULT;

  // Sequencer: accept, pulse start, wait for ready or timeout, one writeback beat
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_state     <= S_IDLE;
      r_opA       <= 32'd0;
      r_opB       <= 32'd0;
      r_rd        <= 5'd0;
      r_is_div    <= 1'b0;
      r_cnt       <= '0;
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
    end else begin
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // mult wins when both request bits are set
            r_opA       <= bus.x_opA;
            r_opB       <= bus.x_opB;
            r_rd        <= bus.x_rd;
            r_is_div    <= ~bus.x_is_mult;
            r_ctrl_mult <= bus.x_is_mult;
            r_ctrl_div  <= ~bus.x_is_mult;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (bus.md_resultRDY) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= bus.md_exception ? EXC_RD : r_rd;
            r_wb_data  <= bus.md_exception ? w_exc_code : bus.md_result;
            r_state    <= S_DONE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= EXC_RD;
            r_wb_data  <= w_exc_code;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          // instruction still in X here is the one just completed
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Freeze F/D/X while an op is pending; released in DONE so the result travels with it
  assign bus.stall = ((r_state == S_IDLE) & w_req) |
                     (r_state == S_START) |
                     (r_state == S_BUSY);

  assign bus.md_operandA  = r_opA;
  assign bus.md_operandB  = r_opB;
  assign bus.md_ctrl_MULT = r_ctrl_mult;
  assign bus.md_ctrl_DIV  = r_ctrl_div;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_rd        = r_wb_rd;
  assign bus.wb_data      = r_wb_data;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus randomized ops against a cycle-level reference model.
module tb_md_issue_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   gcyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic        x_is_mult = 1'b0, x_is_div = 1'b0;
  logic [31:0] x_opA = 32'd0, x_opB = 32'd0;
  logic [4:0]  x_rd = 5'd0;
  logic [31:0] md_result = 32'd0;
  logic        md_exception = 1'b0, md_resultRDY = 1'b0;

  md_issue_ctrl_if b0 ();
  md_issue_ctrl_if b1 ();

  assign b0.x_is_mult = x_is_mult;    assign b1.x_is_mult = x_is_mult;
  assign b0.x_is_div = x_is_div;      assign b1.x_is_div = x_is_div;
  assign b0.x_opA = x_opA;            assign b1.x_opA = x_opA;
  assign b0.x_opB = x_opB;            assign b1.x_opB = x_opB;
  assign b0.x_rd = x_rd;              assign b1.x_rd = x_rd;
  assign b0.md_result = md_result;    assign b1.md_result = md_result;
  assign b0.md_exception = md_exception;  assign b1.md_exception = md_exception;
  assign b0.md_resultRDY = md_resultRDY;  assign b1.md_resultRDY = md_resultRDY;

  md_issue_ctrl #(.TIMEOUT(40)) u0 (.clock(clk), .ctrl_reset_n(rst_n), .bus(b0));
  md_issue_ctrl #(.TIMEOUT(8))  u1 (.clock(clk), .ctrl_reset_n(rst_n), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // sampled view of the selected DUT
  logic        s_stall, s_wbv, s_cm, s_cd;
  logic [4:0]  s_rd;
  logic [31:0] s_wd, s_oa, s_ob;

  task automatic sample(input bit sel);
    if (sel) begin
      s_stall = b1.stall; s_wbv = b1.wb_valid; s_cm = b1.md_ctrl_MULT; s_cd = b1.md_ctrl_DIV;
      s_rd = b1.wb_rd; s_wd = b1.wb_data; s_oa = b1.md_operandA; s_ob = b1.md_operandB;
    end else begin
      s_stall = b0.stall; s_wbv = b0.wb_valid; s_cm = b0.md_ctrl_MULT; s_cd = b0.md_ctrl_DIV;
      s_rd = b0.wb_rd; s_wd = b0.wb_data; s_oa = b0.md_operandA; s_ob = b0.md_operandB;
    end
  endtask

  // observations of one operation
  int          o_nmult, o_ndiv, o_pulse_cyc, o_pulse_g, o_wb_cyc, o_wb_g, o_nwb, o_stall_cnt, o_opnd_bad;
  bit          o_hang;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;

  // expected results of one operation
  int          e_wb_cyc;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  bit          e_mult;

  // Reference: ready at cycle delay+1 counts if it lands within the TIMEOUT busy cycles (2..to+1)
  task automatic model_op(input bit m, input logic [4:0] rd, input int delay,
                          input logic [31:0] res, input bit exc, input int to);
    bit ready, x;
    e_mult   = m;
    ready    = (delay >= 1) && (delay <= to);
    x        = ready ? exc : 1'b1;
    e_wb_cyc = ready ? delay + 2 : to + 2;
    e_rd     = x ? 5'd30 : rd;
    e_data   = x ? (m ? 32'd4 : 32'd5) : res;
  endtask

  // Drive one request (cycle 0 = request seen in IDLE) and record what the DUT does
  task automatic drive_op(input bit sel, input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int delay,
                          input logic [31:0] res, input bit exc, input bit hold, input int tail);
    int cyc;
    bit wb_prev, req;
    cyc = 0; wb_prev = 0;
    o_nmult = 0; o_ndiv = 0; o_pulse_cyc = -1; o_pulse_g = -1; o_wb_cyc = -1; o_wb_g = -1;
    o_nwb = 0; o_stall_cnt = 0; o_opnd_bad = 0; o_hang = 0; o_wb_rd = 5'd0; o_wb_data = 32'd0;
    forever begin
      @(negedge clk);
      req = (cyc == 0) || (hold && !wb_prev);
      x_is_mult = req & m;
      x_is_div  = req & d;
      x_opA     = req ? a : $urandom;
      x_opB     = req ? b : $urandom;
      x_rd      = req ? rd : 5'($urandom);
      if (delay > 0 && cyc == delay + 1) begin
        md_resultRDY = 1'b1; md_result = res; md_exception = exc;
      end else if ((cyc <= 1 || wb_prev) && $urandom_range(0, 3) == 0) begin
        md_resultRDY = 1'b1; md_result = $urandom; md_exception = 1'($urandom);
      end else begin
        md_resultRDY = 1'b0; md_result = $urandom; md_exception = 1'b0;
      end
      #1;
      sample(sel);
      if (s_stall) o_stall_cnt++;
      if (s_cm) begin o_nmult++; o_pulse_cyc = cyc; o_pulse_g = gcyc; end
      if (s_cd) begin o_ndiv++;  o_pulse_cyc = cyc; o_pulse_g = gcyc; end
      if (s_wbv) begin
        o_nwb++;
        if (o_wb_cyc < 0) begin o_wb_cyc = cyc; o_wb_g = gcyc; o_wb_rd = s_rd; o_wb_data = s_wd; end
      end
      if (cyc >= 1 && !wb_prev && (s_oa !== a || s_ob !== b)) o_opnd_bad++;
      if (o_wb_cyc >= 0 && cyc >= o_wb_cyc + tail) break;
      if (cyc >= 70) begin o_hang = 1; break; end
      wb_prev = (o_wb_cyc >= 0);
      cyc++;
    end
  endtask

  task automatic quiet_inputs();
    x_is_mult = 0; x_is_div = 0; x_opA = 0; x_opB = 0; x_rd = 0;
    md_resultRDY = 0; md_result = 0; md_exception = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); quiet_inputs(); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    logic [105:0] v;
    quiet_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s[0]);
      v = {s_stall, s_wbv, s_cm, s_cd, s_rd, s_wd, s_oa, s_ob};
      n_checks++;
      if (v !== '0) begin n_errors++; $display("FAIL reset_outputs dut%0d got %h exp 0", s, v); end
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_mult();
    drive_op(0, 1, 0, 32'd7, 32'd6, 5'd5, 33, 32'd42, 0, 1, 2);
    model_op(1, 5'd5, 33, 32'd42, 0, 40);
    n_checks++; if (o_hang) begin n_errors++; $display("FAIL mult_hang got no writeback exp writeback"); end
    n_checks++; if (o_nmult !== 1 || o_ndiv !== 0) begin n_errors++; $display("FAIL mult_pulses got mult=%0d div=%0d exp 1/0", o_nmult, o_ndiv); end
    n_checks++; if (o_pulse_cyc !== 1) begin n_errors++; $display("FAIL mult_pulse_cycle got %0d exp 1", o_pulse_cyc); end
    n_checks++; if (o_opnd_bad !== 0) begin n_errors++; $display("FAIL mult_operands got %0d unstable cycles exp 0", o_opnd_bad); end
    n_checks++; if (o_nwb !== 1 || o_wb_cyc !== e_wb_cyc) begin n_errors++; $display("FAIL mult_wb_timing got n=%0d cyc=%0d exp 1/%0d", o_nwb, o_wb_cyc, e_wb_cyc); end
    n_checks++; if (o_wb_rd !== e_rd || o_wb_data !== e_data) begin n_errors++; $display("FAIL mult_wb_value got %0d/%0d exp %0d/%0d", o_wb_rd, o_wb_data, e_rd, e_data); end
    n_checks++; if (o_stall_cnt !== 35) begin n_errors++; $display("FAIL mult_stall_cycles got %0d exp 35", o_stall_cnt); end
  endtask

  task automatic test_div_exc();
    int dl;
    dl = $urandom_range(1, 20);
    drive_op(0, 0, 1, 32'd100, 32'd0, 5'd9, dl, $urandom, 1, 0, 2);
    model_op(0, 5'd9, dl, 32'd0, 1, 40);
    n_checks++; if (o_ndiv !== 1 || o_nmult !== 0) begin n_errors++; $display("FAIL div_pulses got mult=%0d div=%0d exp 0/1", o_nmult, o_ndiv); end
    n_checks++; if (o_wb_rd !== 5'd30 || o_wb_data !== 32'd5 || o_wb_cyc !== e_wb_cyc) begin
      n_errors++; $display("FAIL div_exc_wb got rd=%0d data=%0d cyc=%0d exp 30/5/%0d", o_wb_rd, o_wb_data, o_wb_cyc, e_wb_cyc); end
    n_checks++; if (o_stall_cnt !== e_wb_cyc) begin n_errors++; $display("FAIL div_stall_cycles got %0d exp %0d", o_stall_cnt, e_wb_cyc); end
  endtask

  task automatic test_mult_ovf();
    drive_op(0, 1, 0, 32'h7FFF_FFFF, 32'd2, 5'd12, 4, 32'hFFFF_FFFE, 1, 1, 2);
    n_checks++; if (o_wb_rd !== 5'd30 || o_wb_data !== 32'd4 || o_nwb !== 1) begin
      n_errors++; $display("FAIL mult_ovf_wb got rd=%0d data=%0d n=%0d exp 30/4/1", o_wb_rd, o_wb_data, o_nwb); end
  endtask

  task automatic test_back_to_back();
    int done_g;
    drive_op(0, 1, 0, 32'd3, 32'd5, 5'd1, 10, 32'd15, 0, 1, 0);
    done_g = o_wb_g;
    n_checks++; if (o_nmult !== 1 || o_nwb !== 1) begin n_errors++; $display("FAIL b2b_first got mult=%0d wb=%0d exp 1/1", o_nmult, o_nwb); end
    // div at the minimum latency right behind it
    drive_op(0, 0, 1, 32'd20, 32'd4, 5'd2, 1, 32'd5, 0, 1, 2);
    model_op(0, 5'd2, 1, 32'd5, 0, 40);
    n_checks++; if (o_nmult !== 0 || o_ndiv !== 1) begin n_errors++; $display("FAIL b2b_second_pulses got mult=%0d div=%0d exp 0/1", o_nmult, o_ndiv); end
    n_checks++; if (o_pulse_g - done_g !== 2) begin n_errors++; $display("FAIL b2b_gap got %0d exp 2", o_pulse_g - done_g); end
    n_checks++; if (o_wb_cyc !== 3 || o_wb_rd !== e_rd || o_wb_data !== e_data) begin
      n_errors++; $display("FAIL b2b_min_latency got cyc=%0d rd=%0d data=%0d exp 3/%0d/%0d", o_wb_cyc, o_wb_rd, o_wb_data, e_rd, e_data); end
  endtask

  task automatic test_random();
    bit m, d, exc, hold;
    int r, dl;
    logic [31:0] a, b, res;
    logic [4:0] rd;
    for (int i = 0; i < 14; i++) begin
      m = 1'($urandom_range(0, 1));
      d = m ? 1'($urandom_range(0, 1)) : 1'b1;
      a = $urandom; b = $urandom; res = $urandom; rd = 5'($urandom);
      r = $urandom_range(0, 9);
      dl = (r == 0) ? 0 : (r == 1) ? 40 : $urandom_range(1, 39);
      exc = ($urandom_range(0, 3) == 0);
      hold = 1'($urandom_range(0, 1));
      drive_op(0, m, d, a, b, rd, dl, res, exc, hold, 1);
      model_op(m, rd, dl, res, exc, 40);
      n_checks++;
      if (o_nwb !== 1 || o_wb_cyc !== e_wb_cyc || o_wb_rd !== e_rd || o_wb_data !== e_data) begin
        n_errors++;
        $display("FAIL rand%0d_wb got n=%0d cyc=%0d rd=%0d data=%h exp 1/%0d/%0d/%h", i, o_nwb, o_wb_cyc, o_wb_rd, o_wb_data, e_wb_cyc, e_rd, e_data);
      end
      n_checks++;
      if (o_nmult !== int'(e_mult) || o_ndiv !== int'(!e_mult) || o_pulse_cyc !== 1) begin
        n_errors++; $display("FAIL rand%0d_pulse got mult=%0d div=%0d cyc=%0d exp %0d/%0d/1", i, o_nmult, o_ndiv, o_pulse_cyc, e_mult, !e_mult);
      end
      n_checks++;
      if (o_stall_cnt !== e_wb_cyc || o_opnd_bad !== 0) begin
        n_errors++; $display("FAIL rand%0d_stall_opnd got stall=%0d bad=%0d exp %0d/0", i, o_stall_cnt, o_opnd_bad, e_wb_cyc);
      end
    end
  endtask

  task automatic test_timeout();
    pulse_reset();
    drive_op(1, 1, 0, 32'd9, 32'd9, 5'd7, 0, 32'd81, 0, 1, 2);
    n_checks++; if (o_wb_cyc !== 10 || o_wb_rd !== 5'd30 || o_wb_data !== 32'd4 || o_stall_cnt !== 10) begin
      n_errors++; $display("FAIL timeout_never_ready got cyc=%0d rd=%0d data=%0d stall=%0d exp 10/30/4/10", o_wb_cyc, o_wb_rd, o_wb_data, o_stall_cnt); end
    // ready in the last busy cycle still wins
    drive_op(1, 0, 1, 32'd50, 32'd7, 5'd3, 8, 32'd7, 0, 0, 2);
    model_op(0, 5'd3, 8, 32'd7, 0, 8);
    n_checks++; if (o_wb_cyc !== e_wb_cyc || o_wb_rd !== e_rd || o_wb_data !== e_data) begin
      n_errors++; $display("FAIL timeout_last_cycle_ready got cyc=%0d rd=%0d data=%0d exp %0d/%0d/%0d", o_wb_cyc, o_wb_rd, o_wb_data, e_wb_cyc, e_rd, e_data); end
    // ready one cycle too late lands in DONE and is ignored
    drive_op(1, 0, 1, 32'd50, 32'd7, 5'd3, 9, 32'd7, 0, 0, 2);
    model_op(0, 5'd3, 9, 32'd7, 0, 8);
    n_checks++; if (o_wb_cyc !== e_wb_cyc || o_wb_rd !== e_rd || o_wb_data !== e_data || o_nwb !== 1) begin
      n_errors++; $display("FAIL timeout_late_ready got cyc=%0d rd=%0d data=%0d n=%0d exp %0d/%0d/%0d/1", o_wb_cyc, o_wb_rd, o_wb_data, o_nwb, e_wb_cyc, e_rd, e_data); end
  endtask

  task automatic test_reset_mid();
    logic [105:0] v;
    int bad;
    pulse_reset();
    @(negedge clk);
    x_is_mult = 1; x_opA = 32'd11; x_opB = 32'd13; x_rd = 5'd4;
    repeat (8) @(negedge clk);
    #2;
    quiet_inputs();
    rst_n = 0;
    #1;
    sample(0);
    v = {s_stall, s_wbv, s_cm, s_cd, s_rd, s_wd, s_oa, s_ob};
    n_checks++;
    if (v !== '0) begin n_errors++; $display("FAIL reset_mid_outputs got %h exp 0", v); end
    @(negedge clk); rst_n = 1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      md_resultRDY = (c % 3 == 0); md_result = $urandom; md_exception = 1'($urandom);
      #1; sample(0);
      if (s_wbv || s_stall || s_cm || s_cd) bad++;
    end
    quiet_inputs();
    n_checks++;
    if (bad !== 0) begin n_errors++; $display("FAIL reset_late_ready got %0d active cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_exc();
    test_mult_ovf();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Sequencing controller between the execute stage and the `multdiv` unit. It latches a multiply or divide request from X, issues a one-cycle `ctrl_MULT`/`ctrl_DIV` pulse with held operands, and stalls the pipeline while the unit runs. It captures `data_result`/`data_exception` on `data_resultRDY` and presents a single writeback beat to the instruction leaving X. On exception it redirects the writeback to `$rstatus`.

## Interface
- `TIMEOUT`, default 40: maximum cycles spent in BUSY before a forced completion.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `ctrl_reset_n`  in  1  asynchronous, active-low reset.
- `x_is_mult`  in  1  instruction in X is `mul`.
- `x_is_div`  in  1  instruction in X is `div`.
- `x_opA`  in  32  rs value from X.
- `x_opB`  in  32  rt value from X.
- `x_rd`  in  5  destination register from X.
- `md_operandA`  out  32  registered operand A to multdiv.
- `md_operandB`  out  32  registered operand B to multdiv.
- `md_ctrl_MULT`  out  1  start pulse for multiply.
- `md_ctrl_DIV`  out  1  start pulse for divide.
- `md_result`  in  32  multdiv `data_result`.
- `md_exception`  in  1  multdiv `data_exception`.
- `md_resultRDY`  in  1  multdiv `data_resultRDY`.
- `stall`  out  1  combinational freeze of F/D/X latches and PC.
- `wb_valid`  out  1  writeback beat valid.
- `wb_rd`  out  5  writeback destination.
- `wb_data`  out  32  writeback value.

## Operation
- FSM has four states: IDLE, START, BUSY and DONE. Reset state is IDLE.
- **IDLE**
  - Leaves for START when `x_is_mult | x_is_div`.
  - On that edge it latches `x_opA`, `x_opB`, `x_rd` and the op type.
  - If both request bits are high, the op is mult.
- **START**
  - Asserts exactly one of `md_ctrl_MULT`/`md_ctrl_DIV` for one cycle.
  - Clears the cycle counter and moves to BUSY.
- **BUSY**
  - Counter increments each cycle.
  - On `md_resultRDY`, captures `md_result` and `md_exception` and moves to DONE.
  - If the counter reaches `TIMEOUT-1` without ready, moves to DONE with the exception flag forced to 1.
- **DONE**
  - `wb_valid`=1 for one cycle, then returns to IDLE unconditionally.
  - A request still visible in X during DONE is the same instruction and is not re-issued.
- **Writeback value**
  - No exception: `wb_rd` = latched rd, `wb_data` = captured result.
  - Exception: `wb_rd`=30, `wb_data`=4 for mult or 5 for div.
  - rd=0 still produces `wb_valid`; the register file discards it.
- `md_operandA/B` hold the latched values from START through DONE and do not change while not in IDLE.
- `md_resultRDY` outside BUSY is ignored.
- Requests arriving while not in IDLE are not accepted; `stall` keeps them in X.

## Timing
- `stall` = (IDLE & request) | START | BUSY; it is deasserted in DONE so the instruction advances with its result.
- Cycle numbering:
  - Cycle 0: request seen in IDLE; `stall`=1.
  - Cycle 1: START; ctrl pulse high.
  - Cycle 2 onward: BUSY.
  - Ready seen at cycle k: DONE at k+1 with `wb_valid`=1 and `stall`=0.
  - IDLE at k+2; a new request may be accepted that cycle.
- Minimum request-to-writeback latency is 3 cycles, occurring when ready arrives in the first BUSY cycle.
- Back-to-back ops: the next op's ctrl pulse is at least 2 cycles after the previous DONE.
- Reset values: state IDLE, all registers 0.
  - All outputs are 0: `stall`, `wb_valid`, `wb_rd`, `wb_data`, both ctrl pulses, both operands.
- Reset mid-operation clears immediately and asynchronously. A pending ctrl pulse or writeback is dropped, and a late `md_resultRDY` after reset is ignored.

## Test plan
- **mult 7×6, rd=5, ready 33 cycles after the pulse**
  - Exactly one `md_ctrl_MULT` pulse.
  - Operands stable at 7/6 through DONE.
  - `wb_valid` one cycle with rd=5, data=42.
  - `stall` high for 35 cycles.
- **div 100/0, rd=9, ready with exception**
  - `wb_rd`=30, `wb_data`=5.
  - No writeback to r9.
- **mult overflow 0x7FFFFFFF×2 with exception**
  - `wb_rd`=30, `wb_data`=4.
- **`x_is_mult` held high through DONE, then a new div issued the following cycle**
  - Exactly one `md_ctrl_MULT` pulse, then one `md_ctrl_DIV` pulse 2 cycles after DONE.
- **`TIMEOUT`=8, ready never asserted**
  - DONE at BUSY cycle 8 with `wb_rd`=30 and `wb_data`=4.
- **`ctrl_reset_n` dropped during BUSY, then ready pulses after release**
  - All outputs 0 immediately.
  - No `wb_valid`; FSM stays in IDLE.
